// File: rtl/haar_rect_reader.sv
// haar_rect_reader
//   Reads the corner values of up to two rectangles from a WIN_W x WIN_H
//   integral image and evaluates one weighted Haar-like feature per START.
//   Each rectangle sum is I(D) - I(B) - I(C) + I(A). Each sum is scaled by its
//   signed weight and accumulated, and the total is compared to a threshold.
//
// Ports
//   CLK, Reset        clock, synchronous active-high reset
//   START             begin an evaluation (accepted only when idle)
//   R0_* / R1_*       rectangle geometry (col, row, width, height) and signed
//                     weight; R1_WGT = 0 disables rectangle 1
//   THRESH            signed pass threshold
//   RD_EN, RD_ADDR    read strobe and address into the integral buffer
//   RD_DATA           integral value, returned one cycle after RD_EN
//   BUSY, DONE        evaluation in progress / one-cycle completion pulse
//   FEAT_SUM          signed weighted feature sum
//   FEAT_PASS         FEAT_SUM >= THRESH
//   ERR               rectangle geometry rejected, no reads performed
module haar_rect_reader #(
    parameter int WIN_W  = 20,
    parameter int WIN_H  = 20,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              START,
    input  logic [4:0]        R0_X,
    input  logic [4:0]        R0_Y,
    input  logic [4:0]        R0_W,
    input  logic [4:0]        R0_H,
    input  logic [3:0]        R0_WGT,
    input  logic [4:0]        R1_X,
    input  logic [4:0]        R1_Y,
    input  logic [4:0]        R1_W,
    input  logic [4:0]        R1_H,
    input  logic [3:0]        R1_WGT,
    input  logic [ACC_W-1:0]  THRESH,
    output logic              RD_EN,
    output logic [8:0]        RD_ADDR,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [ACC_W-1:0]  FEAT_SUM,
    output logic              FEAT_PASS,
    output logic              ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_ACC,
        S_RESULT
    } state_t;

    state_t state, state_nxt;

    // Latched request
    logic [4:0]              gx [2];
    logic [4:0]              gy [2];
    logic [4:0]              gw [2];
    logic [4:0]              gh [2];
    logic signed [3:0]       gwgt [2];
    logic signed [ACC_W-1:0] thresh_q;

    // Corner list derived from the latched geometry
    logic [8:0] c_addr [8];
    logic       c_neg  [8];
    logic       c_last [8];
    logic       c_rect [8];
    logic [3:0] c_cnt;

    logic [2:0] idx;
    logic       fetch_last;
    logic       geom_bad;

    // Read-return stage tags
    logic       vld_p1;
    logic       rd_neg_p1;
    logic       rd_last_p1;
    logic       rd_rect_p1;

    logic signed [ACC_W-1:0] rect_acc;
    logic signed [ACC_W-1:0] feat_acc;
    logic signed [ACC_W-1:0] rd_ext;
    logic signed [ACC_W-1:0] rect_sum;
    logic signed [ACC_W-1:0] feat_nxt;

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    function automatic logic rect_bad(input logic [4:0] x, input logic [4:0] y,
                                      input logic [4:0] w, input logic [4:0] h);
        return (w == 5'd0) || (h == 5'd0) ||
               ({1'b0, x} + {1'b0, w} > 6'(WIN_W)) ||
               ({1'b0, y} + {1'b0, h} > 6'(WIN_H));
    endfunction

    // Corner code k: 0 = D (bottom-right), 1 = B (above), 2 = C (left), 3 = A.
    // Bit 0 selects the row above the rectangle, bit 1 the column to its left.
    function automatic logic corner_used(input logic [1:0] k, input logic [4:0] x,
                                         input logic [4:0] y);
        return (!k[0] || (y != 5'd0)) && (!k[1] || (x != 5'd0));
    endfunction

    // The last corner that is actually read closes the rectangle.
    function automatic logic corner_last(input logic [1:0] k, input logic [4:0] x,
                                         input logic [4:0] y);
        return (k == 2'd3) ||
               ((k == 2'd2) && (y == 5'd0)) ||
               ((k == 2'd1) && (x == 5'd0)) ||
               ((k == 2'd0) && (x == 5'd0) && (y == 5'd0));
    endfunction

    function automatic logic [8:0] corner_addr(input logic [1:0] k,
                                               input logic [4:0] x, input logic [4:0] y,
                                               input logic [4:0] w, input logic [4:0] h);
        logic [4:0] row;
        logic [4:0] col;
        int         a;
        row = k[0] ? (y - 5'd1) : (y + h - 5'd1);
        col = k[1] ? (x - 5'd1) : (x + w - 5'd1);
        a   = int'(row) * WIN_W + int'(col);
        return a[8:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] weight_term(
        input logic signed [ACC_W-1:0] s, input logic signed [3:0] w);
        logic signed [ACC_W-1:0] wx;
        wx = {{(ACC_W-4){w[3]}}, w};
        return s * wx;   // wraps modulo 2^ACC_W
    endfunction

    // ---------------------------------------------------------------------
    // Geometry check and corner list
    // ---------------------------------------------------------------------
    assign geom_bad = rect_bad(gx[0], gy[0], gw[0], gh[0]) ||
                      ((gwgt[1] != 4'sd0) && rect_bad(gx[1], gy[1], gw[1], gh[1]));

    always_comb begin
        c_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            c_addr[i] = '0;
            c_neg[i]  = 1'b0;
            c_last[i] = 1'b0;
            c_rect[i] = 1'b0;
        end
        for (int r = 0; r < 2; r++) begin
            if ((r == 0) || (gwgt[1] != 4'sd0)) begin
                for (int k = 0; k < 4; k++) begin
                    if (corner_used(2'(k), gx[r], gy[r])) begin
                        c_addr[c_cnt[2:0]] = corner_addr(2'(k), gx[r], gy[r], gw[r], gh[r]);
                        c_neg[c_cnt[2:0]]  = (k == 1) || (k == 2);
                        c_last[c_cnt[2:0]] = corner_last(2'(k), gx[r], gy[r]);
                        c_rect[c_cnt[2:0]] = (r == 1);
                        c_cnt = c_cnt + 4'd1;
                    end
                end
            end
        end
    end

    assign fetch_last = ({1'b0, idx} + 4'd1) == c_cnt;

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        BUSY      = (state != S_IDLE);
        DONE      = (state == S_RESULT);
        case (state)
            S_IDLE:   if (START) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = geom_bad ? S_RESULT : S_FETCH;
            S_FETCH:  if (fetch_last) state_nxt = S_ACC;
            S_ACC:    state_nxt = S_RESULT;
            S_RESULT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Returned data: zero-extend, apply the corner sign, and close the
    // rectangle into the feature total on its last corner.
    assign rd_ext   = $signed({{(ACC_W-DATA_W){1'b0}}, RD_DATA});
    assign rect_sum = rd_neg_p1 ? (rect_acc - rd_ext) : (rect_acc + rd_ext);
    assign feat_nxt = feat_acc + weight_term(rect_sum, gwgt[rd_rect_p1]);

    // ---------------------------------------------------------------------
    // Stage p0: read issue and control
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= S_IDLE;
            RD_EN     <= 1'b0;
            RD_ADDR   <= '0;
            idx       <= '0;
            vld_p1    <= 1'b0;
            feat_acc  <= '0;
            FEAT_PASS <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= (state == S_FETCH);
            case (state)
                S_IDLE: begin
                    if (START) begin
                        feat_acc  <= '0;
                        FEAT_PASS <= 1'b0;
                        ERR       <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (geom_bad) begin
                        ERR <= 1'b1;
                    end else begin
                        RD_EN   <= 1'b1;
                        RD_ADDR <= c_addr[0];
                        idx     <= '0;
                    end
                end
                S_FETCH: begin
                    if (fetch_last) begin
                        RD_EN <= 1'b0;
                    end else begin
                        idx     <= idx + 3'd1;
                        RD_ADDR <= c_addr[idx + 3'd1];
                    end
                end
                S_ACC: begin
                    FEAT_PASS <= (feat_nxt >= thresh_q);
                end
                default: ;
            endcase
            if (vld_p1 && rd_last_p1) begin
                feat_acc <= feat_nxt;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage p1: request latch, read tags and rectangle accumulation
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if ((state == S_IDLE) && START) begin
            gx[0]    <= R0_X;
            gy[0]    <= R0_Y;
            gw[0]    <= R0_W;
            gh[0]    <= R0_H;
            gwgt[0]  <= R0_WGT;
            gx[1]    <= R1_X;
            gy[1]    <= R1_Y;
            gw[1]    <= R1_W;
            gh[1]    <= R1_H;
            gwgt[1]  <= R1_WGT;
            thresh_q <= THRESH;
            rect_acc <= '0;
        end else if (vld_p1) begin
            rect_acc <= rd_last_p1 ? '0 : rect_sum;
        end
        rd_neg_p1  <= c_neg[idx];
        rd_last_p1 <= c_last[idx];
        rd_rect_p1 <= c_rect[idx];
    end

    assign FEAT_SUM = feat_acc;

endmodule

// File: tb/tb_haar_rect_reader.sv
// Self-checking bench for haar_rect_reader: a stimulus process issues
// features and queues the expected reads and results computed from pixel
// sums; a monitor compares them as the DUT presents RD_EN and DONE.
module tb_haar_rect_reader;
    localparam int WIN_W  = 20;
    localparam int WIN_H  = 20;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 40;

    logic              CLK = 1'b0;
    logic              Reset = 1'b1;
    logic              START = 1'b0;
    logic [4:0]        R0_X = '0, R0_Y = '0, R0_W = '0, R0_H = '0;
    logic [3:0]        R0_WGT = '0;
    logic [4:0]        R1_X = '0, R1_Y = '0, R1_W = '0, R1_H = '0;
    logic [3:0]        R1_WGT = '0;
    logic [ACC_W-1:0]  THRESH = '0;
    logic              RD_EN;
    logic [8:0]        RD_ADDR;
    logic [DATA_W-1:0] RD_DATA = '0;
    logic              BUSY, DONE, FEAT_PASS, ERR;
    logic [ACC_W-1:0]  FEAT_SUM;

    always #5 CLK = ~CLK;

    haar_rect_reader #(.WIN_W(WIN_W), .WIN_H(WIN_H), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .CLK(CLK), .Reset(Reset), .START(START),
        .R0_X(R0_X), .R0_Y(R0_Y), .R0_W(R0_W), .R0_H(R0_H), .R0_WGT(R0_WGT),
        .R1_X(R1_X), .R1_Y(R1_Y), .R1_W(R1_W), .R1_H(R1_H), .R1_WGT(R1_WGT),
        .THRESH(THRESH), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
        .BUSY(BUSY), .DONE(DONE), .FEAT_SUM(FEAT_SUM), .FEAT_PASS(FEAT_PASS), .ERR(ERR)
    );

    // Pixel image and the integral buffer built from it
    int                pix [WIN_H][WIN_W];
    logic [DATA_W-1:0] mem [WIN_W*WIN_H];

    always @(posedge CLK) if (RD_EN) RD_DATA <= mem[RD_ADDR];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct { int x; int y; int w; int h; int wgt; } rect_t;
    typedef struct { logic [ACC_W-1:0] sum; logic pass; logic err; int start; int lat; } res_t;
    typedef struct { logic [8:0] addr; int cyc; } rd_t;

    res_t res_q[$];
    rd_t  rd_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void build_mem();
        longint ii [WIN_H][WIN_W];
        for (int r = 0; r < WIN_H; r++)
            for (int c = 0; c < WIN_W; c++) begin
                longint s;
                s = pix[r][c];
                if (r > 0) s += ii[r-1][c];
                if (c > 0) s += ii[r][c-1];
                if (r > 0 && c > 0) s -= ii[r-1][c-1];
                ii[r][c] = s;
                mem[r*WIN_W + c] = DATA_W'(s);
            end
    endfunction

    function automatic void fill_ones();
        for (int r = 0; r < WIN_H; r++)
            for (int c = 0; c < WIN_W; c++) pix[r][c] = 1;
        build_mem();
    endfunction

    function automatic void fill_random();
        for (int r = 0; r < WIN_H; r++)
            for (int c = 0; c < WIN_W; c++) pix[r][c] = int'($urandom_range(0, 4194303));
        build_mem();
    endfunction

    function automatic bit rect_ok(input rect_t r);
        return r.w > 0 && r.h > 0 && r.x + r.w <= WIN_W && r.y + r.h <= WIN_H;
    endfunction

    function automatic longint pix_sum(input rect_t r);
        longint s = 0;
        for (int row = r.y; row < r.y + r.h; row++)
            for (int col = r.x; col < r.x + r.w; col++) s += pix[row][col];
        return s;
    endfunction

    function automatic bit feat_bad(input rect_t a, input rect_t b);
        return !rect_ok(a) || (b.wgt != 0 && !rect_ok(b));
    endfunction

    function automatic longint feat_model(input rect_t a, input rect_t b);
        longint s;
        if (feat_bad(a, b)) return 0;
        s = pix_sum(a) * a.wgt;
        if (b.wgt != 0) s += pix_sum(b) * b.wgt;
        return s;
    endfunction

    task automatic push_read(input int row, input int col, input int start, inout int n);
        rd_t e;
        e.addr = 9'(row * WIN_W + col);
        e.cyc  = start + 2 + n;
        rd_q.push_back(e);
        n++;
    endtask

    task automatic push_reads(input rect_t r, input int start, inout int n);
        push_read(r.y + r.h - 1, r.x + r.w - 1, start, n);
        if (r.y > 0) push_read(r.y - 1, r.x + r.w - 1, start, n);
        if (r.x > 0) push_read(r.y + r.h - 1, r.x - 1, start, n);
        if (r.x > 0 && r.y > 0) push_read(r.y - 1, r.x - 1, start, n);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"}, 64'({BUSY, DONE, RD_EN, FEAT_PASS, ERR}), 64'd0);
        check({tag, "_addr"}, 64'(RD_ADDR), 64'd0);
        check({tag, "_sum"},  64'(FEAT_SUM), 64'd0);
    endtask

    // Monitor: reads and results are compared as the DUT presents them
    always @(negedge CLK) begin
        rd_t  r;
        res_t e;
        if (RD_EN === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_read actual addr=%0d required no read (cycle %0d)", RD_ADDR, cyc);
            end else begin
                r = rd_q.pop_front();
                check("rd_addr", 64'(RD_ADDR), 64'(r.addr));
                check("rd_cycle", 64'(cyc), 64'(r.cyc));
            end
        end
        if (DONE === 1'b1) begin
            done_cnt++;
            if (res_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_done actual DONE=1 required no DONE (cycle %0d)", cyc);
            end else begin
                e = res_q.pop_front();
                check("feat_sum", 64'(FEAT_SUM), 64'(e.sum));
                check("feat_pass", 64'(FEAT_PASS), 64'(e.pass));
                check("err", 64'(ERR), 64'(e.err));
                check("done_latency", 64'(cyc - e.start), 64'(e.lat));
            end
        end
    end

    // Issue one feature. pulse: extra STARTs while busy with scrambled inputs.
    // abort: Reset asserted during FETCH, no result expected.
    task automatic issue(input rect_t a, input rect_t b, input longint th,
                         input bit pulse, input bit abort);
        int     d0;
        int     n;
        longint fs;
        bit     bad;
        res_t   e;
        bad = feat_bad(a, b);
        fs  = feat_model(a, b);
        @(negedge CLK);
        R0_X = 5'(a.x); R0_Y = 5'(a.y); R0_W = 5'(a.w); R0_H = 5'(a.h); R0_WGT = 4'(a.wgt);
        R1_X = 5'(b.x); R1_Y = 5'(b.y); R1_W = 5'(b.w); R1_H = 5'(b.h); R1_WGT = 4'(b.wgt);
        THRESH = ACC_W'(th);
        START = 1'b1;
        d0 = done_cnt;
        e.start = cyc;
        n = 0;
        if (!bad) begin
            push_reads(a, e.start, n);
            if (b.wgt != 0) push_reads(b, e.start, n);
        end
        e.sum  = ACC_W'(fs);
        e.err  = bad;
        e.pass = !bad && (fs >= th);
        e.lat  = bad ? 2 : n + 3;
        if (!abort) res_q.push_back(e);

        @(negedge CLK);
        START = pulse;
        if (pulse) begin
            R0_X = 5'($urandom); R0_W = 5'($urandom); R0_WGT = 4'($urandom);
            R1_Y = 5'($urandom); R1_WGT = 4'($urandom); THRESH = ACC_W'($urandom);
        end
        if (abort) begin
            @(negedge CLK);
            START = 1'b0;
            @(negedge CLK);
            Reset = 1'b1;
            @(negedge CLK);
            check_idle_outputs("abort_reset");
            check("abort_busy", 64'(BUSY), 64'd0);
            Reset = 1'b0;
            rd_q.delete();
            repeat (6) @(negedge CLK);
            check("abort_no_done", 64'(done_cnt), 64'(d0));
            return;
        end
        if (pulse) begin
            @(negedge CLK);
            START = 1'b0;
            @(negedge CLK);
            START = 1'b1;
            @(negedge CLK);
        end
        START = 1'b0;
        for (int k = 0; k < 40 && done_cnt == d0; k++) @(negedge CLK);
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual no DONE required DONE within 40 cycles (cycle %0d)", cyc);
            res_q.delete();
        end
        check("reads_complete", 64'(rd_q.size()), 64'd0);
        rd_q.delete();
    endtask

    function automatic rect_t rand_rect(input bit allow_off);
        rect_t r;
        r.x   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, WIN_W - 1));
        r.y   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, WIN_H - 1));
        r.w   = int'($urandom_range(1, WIN_W - r.x));
        r.h   = int'($urandom_range(1, WIN_H - r.y));
        r.wgt = int'($urandom_range(0, 15)) - 8;
        if ($urandom_range(0, 9) == 0) begin
            r.x = int'($urandom_range(0, 31));
            r.w = int'($urandom_range(0, 31));
        end
        if ($urandom_range(0, 19) == 0) r.h = 0;
        if (allow_off && $urandom_range(0, 3) == 0) r.wgt = 0;
        return r;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual time limit reached required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rect_t  t1, none, full, inner, bad0, r1off, a, b;
        longint th, ex;
        t1    = '{x: 2, y: 3, w: 4, h: 5, wgt: 1};
        none  = '{x: 0, y: 0, w: 0, h: 0, wgt: 0};
        full  = '{x: 0, y: 0, w: 20, h: 20, wgt: -1};
        inner = '{x: 5, y: 5, w: 10, h: 10, wgt: 2};
        bad0  = '{x: 15, y: 0, w: 6, h: 1, wgt: 1};
        r1off = '{x: 1, y: 1, w: 0, h: 3, wgt: 0};

        Reset = 1'b1;
        fill_ones();
        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        Reset = 1'b0;

        // Interior rectangle, four reads
        issue(t1, none, 20, 0, 0);
        repeat (3) @(negedge CLK);
        check("hold_sum", 64'(FEAT_SUM), 64'd20);
        check("hold_pass", 64'(FEAT_PASS), 64'd1);

        // Two rectangles with corner skipping, threshold boundary
        issue(full, inner, -200, 0, 0);
        issue(full, inner, -199, 0, 0);

        // Invalid R0; ignored invalid R1
        issue(bad0, none, -5, 0, 0);
        issue(t1, r1off, 21, 0, 0);

        // STARTs while busy are ignored
        issue(t1, none, 20, 1, 0);
        repeat (4) @(negedge CLK);
        check("after_pulse_idle", 64'(BUSY), 64'd0);

        // Reset during FETCH, then a clean rerun
        issue(t1, none, 20, 0, 1);
        issue(t1, none, 20, 0, 0);

        // Random sweep
        for (int i = 0; i < 1000; i++) begin
            if (i % 100 == 0) fill_random();
            a  = rand_rect(0);
            b  = rand_rect(1);
            ex = feat_model(a, b);
            case ($urandom_range(0, 2))
                0:       th = (longint'($urandom) <<< 3) - (longint'(1) <<< 34);
                1:       th = ex;
                default: th = ex + 1;
            endcase
            issue(a, b, th, 0, 0);
        end

        repeat (5) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/haar_rect_reader.md
Name: haar_rect_reader

Overview:
- Read-side consumer of the 20x20 integral image that the window integrator writes.
- On START, evaluates one Haar-like feature of up to two weighted rectangles.
  - Fetches only the needed corner values through a 1-cycle-latency read port.
  - Forms the signed weighted sum and compares it against a threshold.
- Sits between the integral buffer and the cascade stage logic.
- Returns one feature result per START with a DONE pulse.

Parameters:
- WIN_W, 20, window width in pixels; integral address = row*WIN_W + col.
- WIN_H, 20, window height in pixels.
- DATA_W, 32, integral entry width (unsigned).
- ACC_W, 40, signed accumulator, FEAT_SUM and THRESH width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- START  in  1  begin evaluation; sampled only in IDLE.
- R0_X, R0_Y, R0_W, R0_H  in  5 each  rectangle 0 origin (col, row) and size.
- R0_WGT  in  4  signed weight of rectangle 0.
- R1_X, R1_Y, R1_W, R1_H  in  5 each  rectangle 1 geometry.
- R1_WGT  in  4  signed weight of rectangle 1; 0 = rectangle unused.
- THRESH  in  ACC_W  signed pass threshold.
- RD_EN  out  1  read strobe to the integral buffer.
- RD_ADDR  out  9  integral address.
- RD_DATA  in  DATA_W  integral value, valid the cycle after RD_EN.
- BUSY  out  1  high from the cycle after START until DONE inclusive.
- DONE  out  1  one-cycle pulse; results are valid from this cycle.
- FEAT_SUM  out  ACC_W  signed weighted feature sum.
- FEAT_PASS  out  1  FEAT_SUM >= THRESH (signed).
- ERR  out  1  invalid geometry detected.

Behaviour:
- Reset: state IDLE. BUSY, DONE, RD_EN, FEAT_PASS, ERR = 0. RD_ADDR = 0, FEAT_SUM = 0.
- Reset mid-operation: abort immediately. RD_EN drops the next edge, any pending RD_DATA is discarded, no DONE is issued.
- States:
  - IDLE: START=1 latches all geometry, weights and THRESH, then goes to CHECK.
  - CHECK: validates geometry. Invalid goes to RESULT with ERR=1, FEAT_SUM=0, FEAT_PASS=0 and no reads; DONE then lands at cycle 2. Valid goes to FETCH.
  - FETCH: issues one RD_EN per cycle, back to back, until the corner list is exhausted.
  - ACC: the cycle after the last read; absorbs the final RD_DATA.
  - RESULT: drives DONE=1, FEAT_SUM and FEAT_PASS, then returns to IDLE.
- Geometry check: a rectangle is invalid if W=0, H=0, X+W>WIN_W or Y+H>WIN_H.
  - R1 is checked only when R1_WGT != 0.
  - R0 is always checked, even when R0_WGT=0.
- Rectangle sum S = I(y+h-1, x+w-1) - I(y-1, x+w-1) - I(y+h-1, x-1) + I(y-1, x-1).
- Corner order per rectangle is D, B, C, A (the four terms above, left to right).
  - B is skipped when y=0, C when x=0, A when x=0 or y=0.
  - Skipped corners count as 0 and issue no read.
- Read order: all R0 corners first, then R1 corners if R1_WGT != 0.
- Read pipeline: the RD_DATA returned for a read issued in cycle n is zero-extended to ACC_W and added or subtracted in cycle n+1.
- After each rectangle completes, S*WGT (sign-extended) is added to the feature accumulator.
- Latency: START in cycle 0, CHECK in cycle 1, N reads in cycles 2..N+1, DONE in cycle N+3. N ranges from 1 to 8.
- START while BUSY is ignored; no queueing.
- FEAT_SUM, FEAT_PASS and ERR hold until the next accepted START, which clears them in the CHECK cycle.
- RD_ADDR holds its last value when RD_EN=0.
- Arithmetic wraps modulo 2^ACC_W. No saturation is required, since 400*max pixel*8 fits in 40 bits.

Test Plan:
- Single rectangle, interior corners:
  - Setup: all-ones image, I(r,c)=(r+1)(c+1). R0=(2,3,4,5), WGT=+1, R1_WGT=0, THRESH=20. START in cycle 0.
  - Expected reads, one per cycle in cycles 2-5: addresses 145, 45, 141, 41.
  - Expected result: DONE in cycle 7, FEAT_SUM=20, PASS=1, ERR=0.
- Two-rectangle feature with corner skipping, same image:
  - Geometry: R0=(0,0,20,20) WGT=-1 (single read at address 399); R1=(5,5,10,10) WGT=+2 (4 reads).
  - Expected result: DONE in cycle 8, FEAT_SUM=-200.
  - Threshold checks: THRESH=-200 gives PASS=1; THRESH=-199 gives PASS=0.
- Invalid geometry:
  - R0 case: R0=(15,0,6,1) gives DONE in cycle 2, ERR=1, FEAT_SUM=0, no RD_EN ever.
  - R1 case: R1_W=0 with R1_WGT=0 evaluates normally with ERR=0.
- START pulsed on the cycle after START and again during FETCH: ignored; exactly one DONE and an identical result.
- Reset asserted during FETCH:
  - Outputs return to reset values the next cycle and no DONE appears.
  - A subsequent START runs the first scenario to FEAT_SUM=20.
- Random image and geometry sweep, 1000 features, compared against a software integral-image model: FEAT_SUM, PASS and the DONE cycle (N+3) all match.
